param_register_bank: RTL

Parametrised general-purpose register bank for the CPU core, successor to the fixed 32x32 two-read-port bank.
- Width, depth and read-port count are configurable.
- Optional write-to-read bypass for same-cycle forwarding.
- Reset is a counted clear sweep: one entry per cycle, with a ready flag, so large banks can map to RAM-style storage.
- Sits between the decode/writeback stages and the debug/VGA register viewers.

---
 rtl/param_register_bank_if.sv | 29 ++
 rtl/param_register_bank.sv | 113 +++++++++++
 2 files changed

// File: rtl/param_register_bank_if.sv
// Bus bundle for param_register_bank: write port, packed read ports,
// debug viewer select/data and sweep status.
interface param_register_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     iRegWrite;
  logic [ADDR_W-1:0]        iWriteRegister;
  logic [DATA_W-1:0]        iWriteData;
  logic [NUM_RD*ADDR_W-1:0] iReadRegister;
  logic [NUM_RD*DATA_W-1:0] oReadData;
  logic [ADDR_W-1:0]        iDebugSelect;
  logic [DATA_W-1:0]        oDebugData;
  logic                     oReady;
  logic [ADDR_W-1:0]        oClearIdx;

  // Core side (decode/writeback plus viewers) drives indices and write data.
  modport master (
    output iRegWrite, iWriteRegister, iWriteData, iReadRegister, iDebugSelect,
    input  oReadData, oDebugData, oReady, oClearIdx
  );

  // Register bank side.
  modport slave (
    input  iRegWrite, iWriteRegister, iWriteData, iReadRegister, iDebugSelect,
    output oReadData, oDebugData, oReady, oClearIdx
  );
endinterface

// File: rtl/param_register_bank.sv
// Parametrised register bank with combinational read ports, optional
// write-to-read bypass and a one-entry-per-cycle clear sweep after reset.
// While the sweep runs, reads return the post-reset value computed from the
// index, so stale storage contents never leak out.
module param_register_bank #(
  parameter int               DATA_W   = 32,
  parameter int               ADDR_W   = 5,
  parameter int               NUM_RD   = 2,
  parameter bit               ZERO_REG = 1'b1,
  parameter int               SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h1001_03FC,
  parameter bit               BYPASS   = 1'b1
) (
  input  logic                iCLK,
  input  logic                iCLR,
  param_register_bank_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_drop;
  logic sweep_wr;
  logic wr_fire;
  logic byp_hit;

  // Value an entry holds right after the sweep has passed it.
  function automatic logic [DATA_W-1:0] clear_value(input logic [ADDR_W-1:0] a);
    return (int'(a) == SP_INDEX) ? SP_INIT : '0;
  endfunction

  assign wr_drop  = ZERO_REG && (bus.iWriteRegister == '0);
  assign sweep_wr = (state_q == S_CLEAR) && !iCLR;
  // iCLR on the same edge beats a write; writes in CLEAR are simply ignored.
  assign wr_fire  = (state_q == S_READY) && !iCLR && bus.iRegWrite && !wr_drop;
  assign byp_hit  = BYPASS && (state_q == S_READY) && bus.iRegWrite && !wr_drop;

  // Sweep sequencing: walk idx up to DEPTH-1, then settle in READY.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_CLEAR) begin
      if (&idx_q) begin
        state_d = S_READY;
      end else begin
        idx_d = idx_q + ADDR_W'(1);
      end
    end
  end

  // State and sweep index; iCLR (re)starts the sweep from index 0.
  always_ff @(posedge iCLK) begin
    if (iCLR) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage has a single write port shared by the sweep and normal writes.
  always_ff @(posedge iCLK) begin
    if (sweep_wr) begin
      mem_q[idx_q] <= clear_value(idx_q);
    end else if (wr_fire) begin
      mem_q[bus.iWriteRegister] <= bus.iWriteData;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_val;

      assign rd_addr = bus.iReadRegister[gi*ADDR_W +: ADDR_W];

      // Read mux: hardwired zero, then sweep value, then bypass, then storage.
      always_comb begin
        rd_val = mem_q[rd_addr];
        if (ZERO_REG && (rd_addr == '0)) begin
          rd_val = '0;
        end else if (state_q == S_CLEAR) begin
          rd_val = clear_value(rd_addr);
        end else if (byp_hit && (rd_addr == bus.iWriteRegister)) begin
          rd_val = bus.iWriteData;
        end
      end

      assign bus.oReadData[gi*DATA_W +: DATA_W] = rd_val;
    end
  endgenerate

  // Viewer port sees committed contents only, never the in-flight write.
  always_comb begin
    bus.oDebugData = mem_q[bus.iDebugSelect];
    if (ZERO_REG && (bus.iDebugSelect == '0)) begin
      bus.oDebugData = '0;
    end else if (state_q == S_CLEAR) begin
      bus.oDebugData = clear_value(bus.iDebugSelect);
    end
  end

  assign bus.oReady    = (state_q == S_READY);
  assign bus.oClearIdx = idx_q;

endmodule
